i2c_accel_responder: RTL and testbench

//  I2C target (responder) modelling the G-sensor at the far end of the accelerometer I2C master's

---
 rtl/i2c_accel_responder.sv | 204 ++++++++++++++++++++
 tb/tb_i2c_accel_responder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_accel_responder.sv
// I2C target modelling the accelerometer G-sensor: address/pointer decode, config register writes,
// and auto-incrementing reads of DEVID, config and a coherent snapshot of the three axis samples.
module i2c_accel_responder #(
  parameter logic [6:0]  DEV_ADDR    = 7'h53,
  parameter logic [7:0]  DEVID_VAL   = 8'hE5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [15:0] axis_x,
  input  logic [15:0] axis_y,
  input  logic [15:0] axis_z,
  output logic [7:0]  bw_rate,
  output logic [7:0]  power_ctl,
  output logic [7:0]  data_format,
  output logic        reg_wr_pulse,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK
  } state_t;

  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_prev, r_sda_prev;
  logic                   w_scl, w_sda;
  logic                   w_scl_rise, w_scl_fall, w_sda_rise, w_sda_fall;
  logic                   w_start, w_stop;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [7:0]  r_shift;
  logic [7:0]  r_ptr;
  logic        r_rw;
  logic [47:0] r_shadow;
  logic        r_sda_oe, r_busy, r_wr_pulse;
  logic [7:0]  r_bw_rate, r_power_ctl, r_data_format;
  logic [7:0]  w_rd_byte;
  logic        w_tx_bit;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
    end
  end

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_prev;
  assign w_scl_fall = ~w_scl & r_scl_prev;
  assign w_sda_rise = w_sda & ~r_sda_prev;
  assign w_sda_fall = ~w_sda & r_sda_prev;
  // SCL must be high in both samples, so an SDA edge coincident with an SCL edge stays data
  assign w_start    = w_sda_fall & w_scl & r_scl_prev;
  assign w_stop     = w_sda_rise & w_scl & r_scl_prev;

  always_comb begin
    w_rd_byte = '0;
    case (r_ptr)
      8'h00:   w_rd_byte = DEVID_VAL;
      8'h2C:   w_rd_byte = r_bw_rate;
      8'h2D:   w_rd_byte = r_power_ctl;
      8'h31:   w_rd_byte = r_data_format;
      8'h32:   w_rd_byte = r_shadow[7:0];
      8'h33:   w_rd_byte = r_shadow[15:8];
      8'h34:   w_rd_byte = r_shadow[23:16];
      8'h35:   w_rd_byte = r_shadow[31:24];
      8'h36:   w_rd_byte = r_shadow[39:32];
      8'h37:   w_rd_byte = r_shadow[47:40];
      default: w_rd_byte = '0;
    endcase
  end

  assign w_tx_bit = w_rd_byte[3'd7 - r_cnt[2:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_shift       <= '0;
      r_ptr         <= '0;
      r_rw          <= 1'b0;
      r_shadow      <= '0;
      r_sda_oe      <= 1'b0;
      r_busy        <= 1'b0;
      r_wr_pulse    <= 1'b0;
      r_bw_rate     <= 8'h0A;
      r_power_ctl   <= '0;
      r_data_format <= '0;
    end else begin
      r_wr_pulse <= 1'b0;
      if (w_start) begin
        r_state  <= S_ADDR;
        r_cnt    <= '0;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
      end else if (w_stop) begin
        r_state  <= S_IDLE;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
      end else begin
        if (w_scl_rise) begin
          case (r_state)
            S_ADDR, S_REG, S_WDATA:
              if (r_cnt != 4'd8) begin
                r_shift <= {r_shift[6:0], w_sda};
                r_cnt   <= r_cnt + 4'd1;
              end
            S_RDATA:
              if (r_cnt != 4'd8) r_cnt <= r_cnt + 4'd1;
            S_RDATA_ACK:
              if (!w_sda) begin
                r_ptr   <= r_ptr + 8'd1;
                r_cnt   <= '0;
                r_state <= S_RDATA;
              end else begin
                r_state <= S_IDLE;
              end
            default: ;
          endcase
        end
        // ACK windows open on the fall after the 8th bit and close on the fall after the 9th
        if (w_scl_fall) begin
          case (r_state)
            S_ADDR:
              if (r_cnt == 4'd8) begin
                if (r_shift[7:1] == DEV_ADDR) begin
                  r_rw     <= r_shift[0];
                  r_sda_oe <= 1'b1;
                  r_busy   <= 1'b1;
                  r_state  <= S_ADDR_ACK;
                  if (r_shift[0]) r_shadow <= {axis_z, axis_y, axis_x};
                end else begin
                  r_state <= S_IDLE;
                end
              end
            S_ADDR_ACK: begin
              r_cnt <= '0;
              if (r_rw) begin
                r_sda_oe <= ~w_rd_byte[7];
                r_state  <= S_RDATA;
              end else begin
                r_sda_oe <= 1'b0;
                r_state  <= S_REG;
              end
            end
            S_REG:
              if (r_cnt == 4'd8) begin
                r_ptr    <= r_shift;
                r_sda_oe <= 1'b1;
                r_state  <= S_REG_ACK;
              end
            S_REG_ACK, S_WDATA_ACK: begin
              r_sda_oe <= 1'b0;
              r_cnt    <= '0;
              r_state  <= S_WDATA;
            end
            S_WDATA:
              if (r_cnt == 4'd8) begin
                case (r_ptr)
                  8'h2C:   r_bw_rate     <= r_shift;
                  8'h2D:   r_power_ctl   <= r_shift;
                  8'h31:   r_data_format <= r_shift;
                  default: ;
                endcase
                r_ptr      <= r_ptr + 8'd1;
                r_wr_pulse <= 1'b1;
                r_sda_oe   <= 1'b1;
                r_state    <= S_WDATA_ACK;
              end
            S_RDATA:
              if (r_cnt == 4'd8) begin
                r_sda_oe <= 1'b0;
                r_state  <= S_RDATA_ACK;
              end else begin
                r_sda_oe <= ~w_tx_bit;
              end
            default: ;
          endcase
        end
      end
    end
  end

  assign sda_oe       = r_sda_oe;
  assign busy         = r_busy;
  assign reg_wr_pulse = r_wr_pulse;
  assign bw_rate      = r_bw_rate;
  assign power_ctl    = r_power_ctl;
  assign data_format  = r_data_format;

endmodule

// File: tb/tb_i2c_accel_responder.sv
// Bench for i2c_accel_responder: bit-banged I2C master on an open-drain bus and a register-map model.
`timescale 1ns/1ps
module tb_i2c_accel_responder;
  localparam int Q = 6;
  localparam logic [7:0] DEVID = 8'hE5;

  logic clk = 1'b0, reset = 1'b1, scl = 1'b1, m_sda = 1'b1;
  logic sda_oe, reg_wr_pulse, busy, w_bus;
  logic [15:0] axis_x = '0, axis_y = '0, axis_z = '0;
  logic [7:0] bw_rate, power_ctl, data_format;

  assign w_bus = m_sda & ~sda_oe;

  i2c_accel_responder #(.DEV_ADDR(7'h53), .DEVID_VAL(8'hE5), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .scl_in(scl), .sda_in(w_bus), .sda_oe(sda_oe),
    .axis_x(axis_x), .axis_y(axis_y), .axis_z(axis_z),
    .bw_rate(bw_rate), .power_ctl(power_ctl), .data_format(data_format),
    .reg_wr_pulse(reg_wr_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int pulses = 0, oe_cnt = 0, viol = 0, scl_hi = 0;
  logic prev_oe = 1'b0;

  // Bus monitor: counts write pulses, SDA drive cycles, and SDA changes during a settled SCL-high
  always @(negedge clk) begin
    if (reg_wr_pulse) pulses++;
    if (sda_oe) oe_cnt++;
    if (sda_oe !== prev_oe && scl_hi > 4) viol++;
    prev_oe = sda_oe;
    scl_hi  = scl ? scl_hi + 1 : 0;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference model of the register map
  logic [7:0]  m_bw, m_pc, m_df, m_ptr;
  logic [47:0] m_shadow;

  task automatic mdl_reset();
    m_bw = 8'h0A; m_pc = 8'h00; m_df = 8'h00; m_ptr = 8'h00;
  endtask

  function automatic logic [7:0] mdl_rd(input logic [7:0] a);
    if (a == 8'h00) return DEVID;
    if (a == 8'h2C) return m_bw;
    if (a == 8'h2D) return m_pc;
    if (a == 8'h31) return m_df;
    if (a >= 8'h32 && a <= 8'h37) return m_shadow[int'(a - 8'h32) * 8 +: 8];
    return 8'h00;
  endfunction

  task automatic mdl_wr(input logic [7:0] d);
    if (m_ptr == 8'h2C) m_bw = d;
    else if (m_ptr == 8'h2D) m_pc = d;
    else if (m_ptr == 8'h31) m_df = d;
    m_ptr = m_ptr + 8'd1;
  endtask

  // Bit-level master
  task automatic waitq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bit_w(input logic b);
    m_sda = b; waitq(); scl = 1'b1; waitq(); waitq(); scl = 1'b0; waitq();
  endtask

  task automatic bit_r(output logic b);
    m_sda = 1'b1; waitq(); scl = 1'b1; waitq(); b = w_bus; waitq(); scl = 1'b0; waitq();
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; waitq(); scl = 1'b1; waitq(); m_sda = 1'b0; waitq(); scl = 1'b0; waitq();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; waitq(); scl = 1'b1; waitq(); m_sda = 1'b1; waitq();
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) bit_w(d[i]);
    bit_r(b);
    ack = ~b;
  endtask

  task automatic rbyte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      bit_r(b);
      d[i] = b;
    end
    bit_w(~ack);
  endtask

  logic [7:0] wr_buf[4];
  logic [7:0] rd_buf[8];
  int n_acks;

  task automatic wr_txn(input logic [7:0] p, input int n);
    logic a;
    n_acks = 0;
    i2c_start();
    wbyte(8'hA6, a); n_acks += int'(a);
    wbyte(p, a);     n_acks += int'(a);
    m_ptr = p;
    for (int i = 0; i < n; i++) begin
      wbyte(wr_buf[i], a); n_acks += int'(a);
      mdl_wr(wr_buf[i]);
    end
    i2c_stop();
    repeat (4) @(negedge clk);
  endtask

  task automatic rd_txn(input logic set_ptr, input logic [7:0] p, input int n, input logic chg);
    logic a;
    logic [7:0] d;
    n_acks = 0;
    i2c_start();
    if (set_ptr) begin
      wbyte(8'hA6, a); n_acks += int'(a);
      wbyte(p, a);     n_acks += int'(a);
      m_ptr = p;
      i2c_start();
    end
    m_shadow = {axis_z, axis_y, axis_x};
    wbyte(8'hA7, a); n_acks += int'(a);
    for (int i = 0; i < n; i++) begin
      rbyte(d, i != n - 1);
      rd_buf[i] = d;
      if (chg && i == 0) begin
        axis_x = 16'($urandom); axis_y = 16'($urandom); axis_z = 16'($urandom);
      end
    end
    i2c_stop();
    repeat (4) @(negedge clk);
  endtask

  // Scenarios
  task automatic test_reset();
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    mdl_reset();
    tests++; if (sda_oe !== 1'b0) begin fails++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (reg_wr_pulse !== 1'b0) begin fails++; $display("FAIL reset_pulse: got %b want 0", reg_wr_pulse); end
    tests++; if (bw_rate !== 8'h0A) begin fails++; $display("FAIL reset_bw_rate: got %h want 0a", bw_rate); end
    tests++; if (power_ctl !== 8'h00) begin fails++; $display("FAIL reset_power_ctl: got %h want 00", power_ctl); end
    tests++; if (data_format !== 8'h00) begin fails++; $display("FAIL reset_data_format: got %h want 00", data_format); end
  endtask

  task automatic test_single_write();
    logic a1, a2, a3;
    int p0 = pulses;
    i2c_start();
    wbyte(8'hA6, a1);
    wbyte(8'h2D, a2);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL write_busy_mid: got %b want 1", busy); end
    wbyte(8'h08, a3);
    i2c_stop();
    repeat (4) @(negedge clk);
    m_ptr = 8'h2D; mdl_wr(8'h08);
    tests++; if ({a1, a2, a3} !== 3'b111) begin fails++; $display("FAIL write_acks: got %b want 111", {a1, a2, a3}); end
    tests++; if (power_ctl !== m_pc) begin fails++; $display("FAIL write_power_ctl: got %h want %h", power_ctl, m_pc); end
    tests++; if (pulses - p0 != 1) begin fails++; $display("FAIL write_pulses: got %0d want 1", pulses - p0); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL write_busy_after_stop: got %b want 0", busy); end
  endtask

  task automatic test_devid_read();
    rd_txn(1'b1, 8'h00, 1, 1'b0);
    tests++; if (n_acks != 3) begin fails++; $display("FAIL devid_acks: got %0d want 3", n_acks); end
    tests++; if (rd_buf[0] !== mdl_rd(m_ptr)) begin fails++; $display("FAIL devid_data: got %h want %h", rd_buf[0], mdl_rd(m_ptr)); end
    tests++; if (busy !== 1'b0 || sda_oe !== 1'b0) begin fails++; $display("FAIL devid_idle: got busy=%b oe=%b want 0 0", busy, sda_oe); end
  endtask

  task automatic test_axis_burst();
    logic [7:0] exp;
    axis_x = 16'h1234; axis_y = 16'hABCD; axis_z = 16'h00FF;
    rd_txn(1'b1, 8'h32, 6, 1'b1);
    for (int i = 0; i < 6; i++) begin
      exp = mdl_rd(m_ptr);
      tests++; if (rd_buf[i] !== exp) begin fails++; $display("FAIL burst_byte%0d: got %h want %h", i, rd_buf[i], exp); end
      if (i < 5) m_ptr = m_ptr + 8'd1;
    end
  endtask

  task automatic test_bad_addr();
    logic a1, a2, a3;
    int p0 = pulses, o0 = oe_cnt;
    i2c_start();
    wbyte(8'h3A, a1);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL badaddr_busy: got %b want 0", busy); end
    wbyte(8'h2C, a2);
    wbyte(8'hFF, a3);
    i2c_stop();
    repeat (4) @(negedge clk);
    tests++; if ({a1, a2, a3} !== 3'b000) begin fails++; $display("FAIL badaddr_acks: got %b want 000", {a1, a2, a3}); end
    tests++; if (oe_cnt != o0) begin fails++; $display("FAIL badaddr_oe: got %0d drive cycles want 0", oe_cnt - o0); end
    tests++; if (bw_rate !== m_bw || pulses != p0) begin fails++; $display("FAIL badaddr_regs: got bw=%h pulses=%0d want bw=%h pulses=0", bw_rate, pulses - p0, m_bw); end
  endtask

  task automatic test_wrap();
    int p0;
    wr_buf[0] = 8'h11;
    wr_txn(8'hFF, 1);
    rd_txn(1'b0, 8'h00, 1, 1'b0);
    tests++; if (rd_buf[0] !== mdl_rd(m_ptr)) begin fails++; $display("FAIL wrap_read0: got %h want %h", rd_buf[0], mdl_rd(m_ptr)); end
    wr_buf[0] = 8'h11; wr_buf[1] = 8'h22;
    p0 = pulses;
    wr_txn(8'hFF, 2);
    tests++; if (n_acks != 4 || pulses - p0 != 2) begin fails++; $display("FAIL wrap_write: got acks=%0d pulses=%0d want 4 2", n_acks, pulses - p0); end
    tests++; if ({bw_rate, power_ctl, data_format} !== {m_bw, m_pc, m_df}) begin fails++; $display("FAIL wrap_cfg: got %h want %h", {bw_rate, power_ctl, data_format}, {m_bw, m_pc, m_df}); end
    rd_txn(1'b0, 8'h00, 1, 1'b0);
    tests++; if (rd_buf[0] !== mdl_rd(m_ptr)) begin fails++; $display("FAIL wrap_read1: got %h want %h", rd_buf[0], mdl_rd(m_ptr)); end
    rd_txn(1'b1, 8'h00, 1, 1'b0);
    tests++; if (rd_buf[0] !== mdl_rd(m_ptr)) begin fails++; $display("FAIL wrap_devid: got %h want %h", rd_buf[0], mdl_rd(m_ptr)); end
  endtask

  task automatic test_random();
    logic [7:0] ptrs[8];
    logic [7:0] p, exp;
    int n, p0;
    for (int it = 0; it < 8; it++) begin
      ptrs = '{8'h00, 8'h2B, 8'h2C, 8'h2D, 8'h31, 8'h32, 8'h35, 8'($urandom)};
      p = ptrs[$urandom_range(0, 7)];
      if ($urandom_range(0, 1) == 0) begin
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) wr_buf[i] = 8'($urandom);
        p0 = pulses;
        wr_txn(p, n);
        tests++; if (n_acks != n + 2 || pulses - p0 != n) begin fails++; $display("FAIL rnd_write_%0d: got acks=%0d pulses=%0d want %0d %0d", it, n_acks, pulses - p0, n + 2, n); end
        tests++; if ({bw_rate, power_ctl, data_format} !== {m_bw, m_pc, m_df}) begin fails++; $display("FAIL rnd_cfg_%0d: got %h want %h", it, {bw_rate, power_ctl, data_format}, {m_bw, m_pc, m_df}); end
      end else begin
        axis_x = 16'($urandom); axis_y = 16'($urandom); axis_z = 16'($urandom);
        n = $urandom_range(1, 4);
        rd_txn(1'b1, p, n, 1'b1);
        tests++; if (n_acks != 3) begin fails++; $display("FAIL rnd_read_acks_%0d: got %0d want 3", it, n_acks); end
        for (int i = 0; i < n; i++) begin
          exp = mdl_rd(m_ptr);
          tests++; if (rd_buf[i] !== exp) begin fails++; $display("FAIL rnd_read_%0d_%0d: ptr %h got %h want %h", it, i, m_ptr, rd_buf[i], exp); end
          if (i < n - 1) m_ptr = m_ptr + 8'd1;
        end
      end
    end
  endtask

  task automatic test_reset_midread();
    logic a;
    wr_buf[0] = 8'h77; wr_txn(8'h2C, 1);
    wr_buf[0] = 8'h0B; wr_txn(8'h31, 1);
    wr_buf[0] = 8'h00; wr_txn(8'h2D, 1);
    i2c_start();
    wbyte(8'hA6, a);
    wbyte(8'h2D, a);
    i2c_start();
    wbyte(8'hA7, a);
    tests++; if (sda_oe !== 1'b1) begin fails++; $display("FAIL midread_driving: got %b want 1", sda_oe); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    tests++; if (sda_oe !== 1'b0) begin fails++; $display("FAIL midread_release: got %b want 0", sda_oe); end
    @(negedge clk);
    mdl_reset();
    tests++; if ({bw_rate, power_ctl, data_format} !== {m_bw, m_pc, m_df}) begin fails++; $display("FAIL midread_cfg: got %h want %h", {bw_rate, power_ctl, data_format}, {m_bw, m_pc, m_df}); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midread_busy: got %b want 0", busy); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    i2c_stop();
    repeat (4) @(negedge clk);
    rd_txn(1'b1, 8'h00, 1, 1'b0);
    tests++; if (n_acks != 3 || rd_buf[0] !== mdl_rd(m_ptr)) begin fails++; $display("FAIL midread_recover: got acks=%0d data=%h want 3 %h", n_acks, rd_buf[0], mdl_rd(m_ptr)); end
  endtask

  task automatic test_scl_high_stable();
    tests++; if (viol != 0) begin fails++; $display("FAIL sda_change_scl_high: got %0d events want 0", viol); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_devid_read();
    test_axis_burst();
    test_bad_addr();
    test_wrap();
    test_random();
    test_reset_midread();
    test_scl_high_stable();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
